udma_rx_lin_addrgen: RTL
========================

Name: udma_rx_lin_addrgen

Overview:
- Linear RX channel engine sitting between a peripheral RX stream and the uDMA L2 write port.
- Latches the channel config (start address, size, datasize, continuous) and accepts data beats from the peripheral.
- Issues one L2 write per beat with an auto-incrementing address and reports curr_addr, bytes_left, en/pending status and an end-of-transfer event.
- Field widths match the uDMA package channel types.

Parameters:
- L2_AWIDTH_NOAL, 21, byte address width (ch_addr_t).
- TRANS_SIZE, 20, transfer size / bytes_left width (ch_transize_t).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  start byte address.
- cfg_size_i  in  TRANS_SIZE  transfer size in bytes.
- cfg_datasize_i  in  2  beat size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- cfg_continuous_i  in  1  reload config at end of transfer.
- cfg_en_i  in  1  start pulse.
- cfg_clr_i  in  1  abort pulse.
- cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next beat address.
- cfg_bytes_left_o  out  TRANS_SIZE  remaining bytes.
- cfg_en_o  out  1  channel busy.
- cfg_pending_o  out  1  queued transfer present.
- evt_o  out  1  one-cycle end-of-transfer pulse.
- err_o  out  1  sticky misalign flag (optional feature).
- data_i  in  32  peripheral data.
- valid_i  in  1  peripheral beat valid.
- ready_o  out  1  beat accepted when valid_i & ready_o.
- l2_req_o  out  1  L2 write request.
- l2_addr_o  out  L2_AWIDTH_NOAL  L2 byte address.
- l2_data_o  out  32  L2 write data.
- l2_datasize_o  out  2  L2 beat size.
- l2_gnt_i  in  1  L2 grant.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; shadow registers empty.
- State machine: IDLE, RUN, LAST, ABORT.
  - step = 1 << datasize (datasize 11 gives step 4).
- IDLE:
  - cfg_en_i with size != 0: load curr_addr = startaddr, bytes_left = size, datasize and continuous; next cycle go to RUN with cfg_en_o = 1.
  - cfg_en_i with size == 0: evt_o pulses the next cycle; no L2 request is made and the state stays IDLE.
- ready_o = (state == RUN) & (~l2_req_o | l2_gnt_i).
  - There is a combinational path from l2_gnt_i to ready_o; this gives back-to-back throughput of one beat per cycle.
- Beat accept (RUN):
  - The one-entry output buffer captures data_i, curr_addr and datasize.
  - l2_req_o rises the following cycle.
  - curr_addr += step (wraps modulo 2^L2_AWIDTH_NOAL).
  - bytes_left = (bytes_left <= step) ? 0 : bytes_left - step.
  - If the old bytes_left <= step, this is the terminal beat: go to LAST. A size that is not a multiple of step ends on this partial beat.
- L2 handshake:
  - l2_req_o and its addr/data/datasize are held stable until l2_gnt_i is sampled high.
  - A request is never withdrawn once raised.
- LAST:
  - ready_o = 0.
  - When the terminal beat is granted, evt_o pulses in the same cycle.
  - Next state, in priority order:
    - pending: load the shadow config, clear pending, go to RUN.
    - continuous: reload the latched startaddr/size, go to RUN.
    - otherwise: go to IDLE with cfg_en_o = 0.
- Queueing:
  - cfg_en_i in RUN or LAST writes the shadow config and sets cfg_pending_o.
  - A second cfg_en_i while pending overwrites the shadow.
- Abort:
  - cfg_clr_i in any state clears pending and stops accepting beats.
  - If l2_req_o is outstanding, go to ABORT until granted, then IDLE. Otherwise go straight to IDLE.
  - No evt_o is produced by an abort.
  - cfg_clr_i and cfg_en_i in the same cycle: clr wins and en is dropped.
- Reset mid-operation: everything clears immediately, including any outstanding l2_req_o.
- cfg_curr_addr_o / cfg_bytes_left_o are registered and reflect the state after the last accepted beat.

Optional Feature:
- Macro: UDMA_RX_LIN_ALIGN_CHK_EN.
- Defined:
  - cfg_en_i with startaddr not aligned to step (datasize 01: addr[0] != 0; datasize 10: addr[1:0] != 0) is ignored: no start, no queueing.
  - err_o is set and stays set until cfg_clr_i or reset.
- Undefined: err_o is tied 0 and misaligned starts proceed with the address as given.

Decomposition:
- Add to udma_pkg:
  - enum udma_rx_lin_state_e {IDLE, RUN, LAST, ABORT}.
  - localparams for the datasize encodings (UDMA_DS_BYTE = 2'b00, UDMA_DS_HALF = 2'b01, UDMA_DS_WORD = 2'b10).
- Reuse ch_addr_t, ch_transize_t, ch_datasize_t and ch_data_t for the ports.
- No sub-module: the shadow register and the one-entry buffer are inline.

Test Plan:
- Basic word transfer: startaddr 0x100, size 12, datasize 10, 3 beats, gnt always 1 -> L2 writes at 0x100, 0x104, 0x108; one evt_o pulse on the third grant; cfg_en_o falls; bytes_left = 0.
- Partial end: size 5, byte beats, startaddr 0x20 -> 5 writes at 0x20..0x24; evt_o once; bytes_left sequence 4, 3, 2, 1, 0.
- Backpressure: gnt low for 3 cycles on the second beat -> l2_req_o and addr/data held stable, ready_o = 0 during the stall, no beat lost or duplicated.
- Pending plus continuous: cfg_en_i mid-transfer with startaddr 0x200 -> cfg_pending_o = 1; after evt_o, next address is 0x200. Separately, continuous with size 8 -> address reloads to the start after each evt_o.
- Abort with an outstanding request: cfg_clr_i while l2_req_o = 1 and gnt = 0 -> req held until gnt, then IDLE; no evt_o; pending cleared. Also clr and en in the same cycle -> stays IDLE.
- UDMA_RX_LIN_ALIGN_CHK_EN: cfg_en_i with startaddr 0x102, datasize 10 -> err_o = 1, cfg_en_o stays 0; cfg_clr_i clears err_o.

Source files
------------

// File: rtl/udma_pkg.sv
// Shared uDMA channel types, datasize encodings and the linear RX engine states.
package udma_pkg;

    localparam int CH_AWIDTH = 21;
    localparam int CH_TWIDTH = 20;

    typedef logic [CH_AWIDTH-1:0] ch_addr_t;
    typedef logic [CH_TWIDTH-1:0] ch_transize_t;
    typedef logic [1:0]           ch_datasize_t;
    typedef logic [31:0]          ch_data_t;

    localparam ch_datasize_t UDMA_DS_BYTE = 2'b00;
    localparam ch_datasize_t UDMA_DS_HALF = 2'b01;
    localparam ch_datasize_t UDMA_DS_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAST,
        ABORT
    } udma_rx_lin_state_e;

    // Encoding 11 is handled as a word beat.
    function automatic logic [2:0] step_of(ch_datasize_t ds);
        logic [2:0] s;
        case (ds)
            UDMA_DS_BYTE: s = 3'd1;
            UDMA_DS_HALF: s = 3'd2;
            default:      s = 3'd4;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/udma_rx_lin_addrgen.sv
// Linear RX channel engine: peripheral beats -> L2 writes with auto-increment.
// Optional start-alignment check when UDMA_RX_LIN_ALIGN_CHK_EN is defined.
module udma_rx_lin_addrgen
    import udma_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = CH_AWIDTH,
    parameter int TRANS_SIZE     = CH_TWIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
    output logic                      cfg_en_o,
    output logic                      cfg_pending_o,
    output logic                      evt_o,
    output logic                      err_o,
    input  logic [31:0]               data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      l2_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
    output logic [31:0]               l2_data_o,
    output logic [1:0]                l2_datasize_o,
    input  logic                      l2_gnt_i
);

    udma_rx_lin_state_e state, state_n;

    logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_n;
    logic [L2_AWIDTH_NOAL-1:0] start_q, start_n;
    logic [TRANS_SIZE-1:0]     left_q, left_n;
    logic [TRANS_SIZE-1:0]     size_q, size_n;
    ch_datasize_t              ds_q, ds_n;
    logic                      cont_q, cont_n;

    logic [L2_AWIDTH_NOAL-1:0] sh_addr_q, sh_addr_n;
    logic [TRANS_SIZE-1:0]     sh_size_q, sh_size_n;
    ch_datasize_t              sh_ds_q, sh_ds_n;
    logic                      sh_cont_q, sh_cont_n;
    logic                      pend_q, pend_n;

    logic                      req_q, req_n;
    logic [L2_AWIDTH_NOAL-1:0] b_addr_q, b_addr_n;
    ch_data_t                  b_data_q, b_data_n;
    ch_datasize_t              b_ds_q, b_ds_n;

    logic evt_q, evt_n, evt_now;
    logic err_q, err_n;
    logic misalign, en_ok, accept, grant, last_beat;
    logic [2:0] step;

`ifdef UDMA_RX_LIN_ALIGN_CHK_EN
    assign misalign = ((cfg_datasize_i == UDMA_DS_HALF) & cfg_startaddr_i[0])
                    | (cfg_datasize_i[1] & (|cfg_startaddr_i[1:0]));
    assign err_n    = ~cfg_clr_i & (err_q | (cfg_en_i & misalign));
`else
    assign misalign = 1'b0;
    assign err_n    = 1'b0;
`endif

    assign step      = step_of(ds_q);
    assign en_ok     = cfg_en_i & ~cfg_clr_i & ~misalign;
    assign ready_o   = (state == RUN) & (~req_q | l2_gnt_i) & ~cfg_clr_i;
    assign accept    = valid_i & ready_o;
    assign grant     = req_q & l2_gnt_i;
    assign last_beat = left_q <= TRANS_SIZE'(step);

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        start_n   = start_q;
        left_n    = left_q;
        size_n    = size_q;
        ds_n      = ds_q;
        cont_n    = cont_q;
        sh_addr_n = sh_addr_q;
        sh_size_n = sh_size_q;
        sh_ds_n   = sh_ds_q;
        sh_cont_n = sh_cont_q;
        pend_n    = pend_q;
        req_n     = req_q;
        b_addr_n  = b_addr_q;
        b_data_n  = b_data_q;
        b_ds_n    = b_ds_q;
        evt_n     = 1'b0;
        evt_now   = 1'b0;

        if (en_ok && state != IDLE) begin
            sh_addr_n = cfg_startaddr_i;
            sh_size_n = cfg_size_i;
            sh_ds_n   = cfg_datasize_i;
            sh_cont_n = cfg_continuous_i;
            pend_n    = 1'b1;
        end

        if (accept) begin
            req_n    = 1'b1;
            b_addr_n = addr_q;
            b_data_n = data_i;
            b_ds_n   = ds_q;
        end else if (grant) begin
            req_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (en_ok) begin
                    if (cfg_size_i != '0) begin
                        addr_n  = cfg_startaddr_i;
                        start_n = cfg_startaddr_i;
                        left_n  = cfg_size_i;
                        size_n  = cfg_size_i;
                        ds_n    = cfg_datasize_i;
                        cont_n  = cfg_continuous_i;
                        state_n = RUN;
                    end else begin
                        evt_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    addr_n = addr_q + L2_AWIDTH_NOAL'(step);
                    left_n = last_beat ? '0 : left_q - TRANS_SIZE'(step);
                    if (last_beat) state_n = LAST;
                end
            end
            LAST: begin
                if (grant) begin
                    evt_now = 1'b1;
                    // pend_n also covers an enable arriving on this very cycle
                    if (pend_n) begin
                        addr_n  = sh_addr_n;
                        start_n = sh_addr_n;
                        left_n  = sh_size_n;
                        size_n  = sh_size_n;
                        ds_n    = sh_ds_n;
                        cont_n  = sh_cont_n;
                        pend_n  = 1'b0;
                        state_n = RUN;
                    end else if (cont_q) begin
                        addr_n  = start_q;
                        left_n  = size_q;
                        state_n = RUN;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            ABORT: begin
                if (grant) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (cfg_clr_i) begin
            pend_n  = 1'b0;
            evt_now = 1'b0;
            state_n = (req_q & ~l2_gnt_i) ? ABORT : IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            start_q   <= '0;
            left_q    <= '0;
            size_q    <= '0;
            ds_q      <= '0;
            cont_q    <= 1'b0;
            sh_addr_q <= '0;
            sh_size_q <= '0;
            sh_ds_q   <= '0;
            sh_cont_q <= 1'b0;
            pend_q    <= 1'b0;
            req_q     <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            b_ds_q    <= '0;
            evt_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            start_q   <= start_n;
            left_q    <= left_n;
            size_q    <= size_n;
            ds_q      <= ds_n;
            cont_q    <= cont_n;
            sh_addr_q <= sh_addr_n;
            sh_size_q <= sh_size_n;
            sh_ds_q   <= sh_ds_n;
            sh_cont_q <= sh_cont_n;
            pend_q    <= pend_n;
            req_q     <= req_n;
            b_addr_q  <= b_addr_n;
            b_data_q  <= b_data_n;
            b_ds_q    <= b_ds_n;
            evt_q     <= evt_n;
            err_q     <= err_n;
        end
    end

    assign cfg_curr_addr_o  = addr_q;
    assign cfg_bytes_left_o = left_q;
    assign cfg_en_o         = state != IDLE;
    assign cfg_pending_o    = pend_q;
    assign evt_o            = evt_q | evt_now;
    assign err_o            = err_q;
    assign l2_req_o         = req_q;
    assign l2_addr_o        = b_addr_q;
    assign l2_data_o        = b_data_q;
    assign l2_datasize_o    = b_ds_q;

endmodule
